// File: rtl/ps2_mouse_rx_if.sv
// Output and line bundle for the PS/2 mouse receiver.
// The receiver side (master) samples the PS/2 lines and drives the cursor/status outputs.
interface ps2_mouse_rx_if;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic [7:0] MouseButtons;
    logic [9:0] BallX;
    logic [9:0] BallY;
    logic       packet_valid;
    logic       frame_err;

    modport master (
        input  PS2_CLK,
        input  PS2_DAT,
        output MouseButtons,
        output BallX,
        output BallY,
        output packet_valid,
        output frame_err
    );

    modport slave (
        output PS2_CLK,
        output PS2_DAT,
        input  MouseButtons,
        input  BallX,
        input  BallY,
        input  packet_valid,
        input  frame_err
    );
endinterface

// File: rtl/ps2_mouse_rx.sv
// Receive-only PS/2 mouse decoder: synchronizes and filters the PS/2 lines, frames
// 11-bit bytes, assembles 3-byte movement packets and tracks a clamped cursor position.
module ps2_mouse_rx #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned X_MAX       = 639,
    parameter int unsigned Y_MAX       = 479,
    parameter int unsigned X_INIT      = 320,
    parameter int unsigned Y_INIT      = 240
) (
    input logic            Clk,
    input logic            Reset,
    ps2_mouse_rx_if.master bus
);

    localparam int unsigned FiltCntW = $clog2(FILTER_LEN + 1);
    localparam int unsigned ToCntW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic signed [10:0] XMaxS = 11'(X_MAX);
    localparam logic signed [10:0] YMaxS = 11'(Y_MAX);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    // Two-flop synchronizers (idle-high lines)
    logic ps2c_s1_q, ps2c_s2_q, ps2d_s1_q, ps2d_s2_q;

    // Glitch filter on the synchronized clock
    logic                filt_clk_q;
    logic [FiltCntW-1:0] filt_cnt_q;
    logic                filt_hit;
    logic                strobe;

    // Byte framing and packet assembly
    state_e            state_q;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        shift_q;
    logic              par_ok_q;
    logic              byte_vld_q;
    logic [ToCntW-1:0] to_cnt_q;
    logic              timeout;
    logic [1:0]        idx_q;
    logic [3:0]        b0_hi_q;   // byte0 bits [7:4]: Y ovf, X ovf, Y sign, X sign
    logic [2:0]        btn_q;     // byte0 bits [2:0]
    logic [7:0]        b1_q;

    // Registered outputs
    logic [7:0] buttons_q;
    logic [9:0] ball_x_q, ball_y_q;
    logic       packet_valid_q, frame_err_q;

    // Next cursor position from the buffered packet (byte2 is still in shift_q)
    logic signed [10:0] dx_ext, dy_ext, sum_x, sum_y;
    logic [9:0]         new_x, new_y;

    assign filt_hit = (ps2c_s2_q != filt_clk_q) && (filt_cnt_q == FiltCntW'(FILTER_LEN - 1));
    // Filtered clock about to fall: sample data this cycle
    assign strobe   = filt_hit && filt_clk_q;
    assign timeout  = (to_cnt_q == ToCntW'(TIMEOUT_CYC)) && ((state_q != StIdle) || (idx_q != 2'd0));

    // Synchronize the asynchronous PS/2 lines
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ps2c_s1_q <= 1'b1;
            ps2c_s2_q <= 1'b1;
            ps2d_s1_q <= 1'b1;
            ps2d_s2_q <= 1'b1;
        end else begin
            ps2c_s1_q <= bus.PS2_CLK;
            ps2c_s2_q <= ps2c_s1_q;
            ps2d_s1_q <= bus.PS2_DAT;
            ps2d_s2_q <= ps2d_s1_q;
        end
    end

    // Accept a new clock level only after FILTER_LEN consecutive differing samples
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            filt_clk_q <= 1'b1;
            filt_cnt_q <= '0;
        end else if (ps2c_s2_q == filt_clk_q) begin
            filt_cnt_q <= '0;
        end else if (filt_hit) begin
            filt_clk_q <= ps2c_s2_q;
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
        end
    end

    // Signed deltas with overflow suppression, then clamp the new cursor position
    always_comb begin
        dx_ext = b0_hi_q[2] ? 11'sd0 : {{3{b0_hi_q[0]}}, b1_q};
        dy_ext = b0_hi_q[3] ? 11'sd0 : {{3{b0_hi_q[1]}}, shift_q};
        sum_x  = $signed({1'b0, ball_x_q}) + dx_ext;
        sum_y  = $signed({1'b0, ball_y_q}) - dy_ext;
        if (sum_x < 0)          new_x = '0;
        else if (sum_x > XMaxS) new_x = XMaxS[9:0];
        else                    new_x = sum_x[9:0];
        if (sum_y < 0)          new_y = '0;
        else if (sum_y > YMaxS) new_y = YMaxS[9:0];
        else                    new_y = sum_y[9:0];
    end

    // Byte FSM, timeout, packet assembly and registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q        <= StIdle;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            par_ok_q       <= 1'b0;
            byte_vld_q     <= 1'b0;
            to_cnt_q       <= '0;
            idx_q          <= 2'd0;
            b0_hi_q        <= '0;
            btn_q          <= '0;
            b1_q           <= '0;
            buttons_q      <= '0;
            ball_x_q       <= 10'(X_INIT);
            ball_y_q       <= 10'(Y_INIT);
            packet_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            byte_vld_q     <= 1'b0;
            packet_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;

            if (strobe || timeout) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q != ToCntW'(TIMEOUT_CYC)) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end

            if (timeout) begin
                state_q     <= StIdle;
                idx_q       <= 2'd0;
                frame_err_q <= 1'b1;
            end else if (strobe) begin
                unique case (state_q)
                    StIdle: begin
                        if (!ps2d_s2_q) begin
                            state_q   <= StData;
                            bit_cnt_q <= '0;
                        end
                    end
                    StData: begin
                        shift_q <= {ps2d_s2_q, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) state_q <= StParity;
                        else                   bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                    StParity: begin
                        par_ok_q <= ^{shift_q, ps2d_s2_q};
                        state_q  <= StStop;
                    end
                    StStop: begin
                        state_q <= StIdle;
                        if (par_ok_q && ps2d_s2_q) begin
                            byte_vld_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                            idx_q       <= 2'd0;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end else if (byte_vld_q) begin
                unique case (idx_q)
                    2'd0: begin
                        // Byte0 must carry the always-one sync bit
                        if (shift_q[3]) begin
                            b0_hi_q <= shift_q[7:4];
                            btn_q   <= shift_q[2:0];
                            idx_q   <= 2'd1;
                        end
                    end
                    2'd1: begin
                        b1_q  <= shift_q;
                        idx_q <= 2'd2;
                    end
                    2'd2: begin
                        buttons_q      <= {5'b0, btn_q};
                        ball_x_q       <= new_x;
                        ball_y_q       <= new_y;
                        packet_valid_q <= 1'b1;
                        idx_q          <= 2'd0;
                    end
                    default: idx_q <= 2'd0;
                endcase
            end
        end
    end

    assign bus.MouseButtons = buttons_q;
    assign bus.BallX        = ball_x_q;
    assign bus.BallY        = ball_y_q;
    assign bus.packet_valid = packet_valid_q;
    assign bus.frame_err    = frame_err_q;

endmodule

// File: doc/ps2_mouse_rx.md
PS2_MOUSE_RX -- requirements
Module: ps2_mouse_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive identical synchronized PS2_CLK samples needed to accept a level.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000: Clk cycles without a bit strobe before a partial byte or packet is aborted.
REQ-003 SHALL have parameters X_MAX = 639, Y_MAX = 479, X_INIT = 320, Y_INIT = 240: cursor bounds and reset position.
REQ-004 SHALL have port Clk, input, 1: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port PS2_CLK, input, 1: mouse clock, asynchronous to Clk.
REQ-007 SHALL have port PS2_DAT, input, 1: mouse data, asynchronous to Clk.
REQ-008 SHALL have port MouseButtons, output, 8: {5'b0, middle, right, left}; right-only = 8'd2.
REQ-009 SHALL have port BallX, output, 10: cursor X, 0..X_MAX.
REQ-010 SHALL have port BallY, output, 10: cursor Y, 0..Y_MAX.
REQ-011 SHALL have port packet_valid, output, 1: one-cycle pulse, coincident with the cursor/button update.
REQ-012 SHALL have port frame_err, output, 1: one-cycle pulse on a parity, stop-bit or timeout error.

Function
REQ-013 SHALL be receive-only and never drive PS2_CLK or PS2_DAT.
REQ-014 SHALL pass PS2_CLK and PS2_DAT through 2-flop synchronizers before use.
REQ-015 SHALL change the filtered clock only after FILTER_LEN equal consecutive samples; a filtered 1->0 transition is a bit strobe, sampling synchronized PS2_DAT.
REQ-016 SHALL run a byte FSM with states IDLE, DATA, PARITY, STOP.
REQ-017 IDLE: a strobe with data 0 (start bit) SHALL go to DATA; a strobe with data 1 SHALL be ignored.
REQ-018 DATA: SHALL shift in 8 bits LSB first, then go to PARITY.
REQ-019 PARITY: SHALL require odd parity over the 8 data bits plus the parity bit, then go to STOP.
REQ-020 STOP: SHALL require data 1, then return to IDLE; a byte is good only if parity and stop bit are both correct.
REQ-021 A bad byte SHALL pulse frame_err, be discarded, and reset the packet index to 0.
REQ-022 SHALL restart the timeout counter on every strobe; reaching TIMEOUT_CYC while the FSM is not IDLE, or while the packet index is nonzero, SHALL force IDLE, index 0, and a frame_err pulse.
REQ-023 Packet assembly, index 0..2: byte0 is accepted only if bit3 = 1; otherwise it is silently discarded and the index stays 0.
REQ-024 Byte1 SHALL be taken as dx and byte2 as dy.
REQ-025 dx SHALL be the 9-bit signed value {b0[4], b1}, forced to 0 if b0[6] (X overflow) is set.
REQ-026 dy SHALL be the 9-bit signed value {b0[5], b2}, forced to 0 if b0[7] (Y overflow) is set.
REQ-027 On a good byte2, one cycle after its stop-bit strobe, SHALL register the update and pulse packet_valid in that same cycle: MouseButtons <= {5'b0, b0[2:0]}, BallX <= clamp(BallX + dx, 0, X_MAX), BallY <= clamp(BallY - dy, 0, Y_MAX).
REQ-028 Sums SHALL be computed as 11-bit signed; negative results clamp to 0, results above the bound clamp to the bound.
REQ-029 Outputs SHALL hold their values between packets; index returns to 0 after byte2.
REQ-030 Back-to-back packets with no idle gap SHALL each be accepted.

Reset
REQ-031 Reset SHALL set MouseButtons = 0, BallX = X_INIT, BallY = Y_INIT, packet_valid = 0, frame_err = 0, FSM = IDLE, index = 0, filter and timeout counters = 0, and filtered clock = 1.
REQ-032 Reset asserted mid-byte or mid-packet SHALL discard all partial data; the first start bit after release begins a new byte at index 0.

Verification
REQ-033 Reset release -> BallX = 320, BallY = 240, MouseButtons = 0, no pulses.
REQ-034 Bytes 0x0A, 0x05, 0x03 -> one packet_valid pulse; MouseButtons = 2, BallX = 325, BallY = 237.
REQ-035 From reset, packet 0x18, 0x00, 0x00 -> BallX = 64; same packet again -> BallX = 0 (clamped); BallY unchanged.
REQ-036 Byte1 sent with bad parity -> frame_err pulse, no packet_valid; next good 3-byte packet updates normally.
REQ-037 Byte 0x02 (bit3 = 0) -> discarded; 5 bits then TIMEOUT_CYC idle -> frame_err pulse; next packet 0x48, 0x7F, 0x00 -> packet_valid, BallX unchanged (X overflow).
REQ-038 PS2_CLK low glitch shorter than FILTER_LEN cycles -> no strobe; outputs unchanged.
